// File: rtl/battle_turn_sched_pkg.sv
// battle_turn_sched_pkg: state codes, move opcodes, battle limits and strobe bundle
package battle_turn_sched_pkg;
  localparam int PP_MAX = 5;
  localparam int HEAL_MAX = 2;
  localparam int CATCH_HP = 4;
  localparam int AI_MISS = 3;
  localparam int PP_W = $clog2(PP_MAX + 1);
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_LOAD = 4'd1, S_P_SEL = 4'd2, S_P_APPLY = 4'd3, S_P_CHK = 4'd4,
    S_P_HEAL = 4'd5, S_CATCH = 4'd6, S_AI_TURN = 4'd7, S_AI_APPLY = 4'd8, S_AI_CHK = 4'd9,
    S_END_TURN = 4'd10, S_WIN = 4'd11, S_LOSS = 4'd12, S_CAUGHT = 4'd13
  } state_t;
  typedef enum logic [1:0] {
    MOVE_ATK = 2'b00, MOVE_HEAL = 2'b01, MOVE_CATCH = 2'b10, MOVE_RSV = 2'b11
  } move_t;
  typedef struct packed {
    logic load, at, tg, aa, ap, ph, ca, rej, vic, los, cau;
  } strobes_t;
endpackage

// File: rtl/battle_turn_sched_pp_bank.sv
// battle_turn_sched_pp_bank: four per-move PP counters, read mux and guarded decrement
//  clk, rst   clock, async active-high reset (refills every counter to PP_MAX)
//  sel        move index for both read and decrement
//  dec        consume one PP of the selected move
//  pp_left    PP remaining for the selected move
module battle_turn_sched_pp_bank
  import battle_turn_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      sel,
  input  logic            dec,
  output logic [PP_W-1:0] pp_left
);
  logic [PP_W-1:0] pp [4];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 4; i++) pp[i] <= PP_W'(PP_MAX);
    else if (dec && pp[sel] != '0) pp[sel] <= pp[sel] - 1'b1;
  assign pp_left = pp[sel];
endmodule

// File: rtl/battle_turn_sched.sv
// battle_turn_sched: player/AI turn sequencer driving the battle datapath strobes
//  clk, rst                     clock, async active-high reset
//  go, move_op, p_move          player command strobe (edge-detected), opcode, attack move index
//  move_accu, rng, ai_hp        datapath accuracy, random value, AI HP
//  p_dead, ai_dead, catch_success  datapath result flags
//  load_ai_hp .. catch          registered one-cycle datapath strobes, turn owner and damage target
//  move_rej                     one-cycle pulse for a refused command
//  victory, loss, caught        sticky end-of-battle flags
//  pp_left, turn_count, state_code  status: selected move PP, completed turns, current state
module battle_turn_sched
  import battle_turn_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] move_op,
  input  logic [1:0] p_move,
  input  logic [3:0] move_accu,
  input  logic [3:0] rng,
  input  logic [3:0] ai_hp,
  input  logic       p_dead,
  input  logic       ai_dead,
  input  logic       catch_success,
  output logic       load_ai_hp,
  output logic       active_trainer,
  output logic       target,
  output logic       apply_ai_damage,
  output logic       apply_p_damage,
  output logic       p_heal,
  output logic       catch,
  output logic       move_rej,
  output logic       victory,
  output logic       loss,
  output logic       caught,
  output logic [2:0] pp_left,
  output logic [7:0] turn_count,
  output logic [3:0] state_code
);
  state_t state, next;
  strobes_t d, q;
  move_t op;
  logic go_r, go_q, edge_go, rej, accept;
  logic [1:0] heals;
  assign op = move_t'(move_op);
  // go is registered before edge detection so no strobe depends combinationally on it
  assign edge_go = state == S_P_SEL && go_r && !go_q;
  assign rej = op == MOVE_RSV || (op == MOVE_ATK && pp_left == '0) ||
               (op == MOVE_HEAL && heals == '0) || (op == MOVE_CATCH && ai_hp > 4'(CATCH_HP));
  assign accept = edge_go && !rej;
  battle_turn_sched_pp_bank u_pp (
    .clk(clk), .rst(rst), .sel(p_move), .dec(accept && op == MOVE_ATK), .pp_left(pp_left)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      go_r <= 1'b0;
      go_q <= 1'b0;
      heals <= 2'(HEAL_MAX);
      turn_count <= '0;
      q <= '0;
    end else begin
      state <= next;
      go_r <= go;
      go_q <= go_r;
      if (accept && op == MOVE_HEAL) heals <= heals - 2'd1;
      if (state == S_END_TURN && turn_count != 8'hFF) turn_count <= turn_count + 8'd1;
      q <= d;
    end
  always_comb begin
    next = state;
    case (state)
      S_IDLE:     next = S_LOAD;
      S_LOAD:     next = S_P_SEL;
      S_P_SEL:    if (accept) next = op == MOVE_ATK ? (rng < move_accu ? S_P_APPLY : S_AI_TURN) :
                                     op == MOVE_HEAL ? S_P_HEAL : S_CATCH;
      S_P_APPLY:  next = S_P_CHK;
      S_P_CHK:    next = ai_dead ? S_WIN : S_AI_TURN;
      S_P_HEAL:   next = S_AI_TURN;
      S_CATCH:    next = catch_success ? S_CAUGHT : S_AI_TURN;
      S_AI_TURN:  next = rng >= 4'(AI_MISS) ? S_AI_APPLY : S_END_TURN;
      S_AI_APPLY: next = S_AI_CHK;
      S_AI_CHK:   next = p_dead ? S_LOSS : S_END_TURN;
      S_END_TURN: next = S_P_SEL;
      S_WIN, S_LOSS, S_CAUGHT: next = state;
      default:    next = S_IDLE;
    endcase
  end
  // strobes are decoded from the next state and registered, so they line up with the state they name
  always_comb begin
    d = '0;
    d.load = next == S_LOAD;
    d.at = next inside {S_AI_TURN, S_AI_APPLY, S_AI_CHK};
    d.tg = next == S_P_APPLY;
    d.aa = next == S_P_APPLY;
    d.ap = next == S_AI_APPLY;
    d.ph = next == S_P_HEAL;
    d.ca = next == S_CATCH;
    d.rej = edge_go && rej;
    d.vic = next == S_WIN;
    d.los = next == S_LOSS;
    d.cau = next == S_CAUGHT;
  end
  assign load_ai_hp = q.load;
  assign active_trainer = q.at;
  assign target = q.tg;
  assign apply_ai_damage = q.aa;
  assign apply_p_damage = q.ap;
  assign p_heal = q.ph;
  assign catch = q.ca;
  assign move_rej = q.rej;
  assign victory = q.vic;
  assign loss = q.los;
  assign caught = q.cau;
  assign state_code = state;
endmodule
